// File: rtl/ripple_sampler.sv
// ripple_sampler: two-flop sync of ripple-divider taps, stability filter, settled count with update strobe.
// Optional sequence checker (seq_err, err_count) is built when RIPPLE_SAMPLER_SEQ_CHECK_EN is defined.
module ripple_sampler #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ripple_in,
  input  logic             clear_err,
  output logic [WIDTH-1:0] count,
  output logic             update,
  output logic             settling
`ifdef RIPPLE_SAMPLER_SEQ_CHECK_EN
  ,
  output logic             seq_err,
  output logic [7:0]       err_count
`endif
);

  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);

  typedef enum logic {TRACK, SETTLE} state_t;

  state_t           state;
  logic [WIDTH-1:0] s1, s2, cand;
  logic [SW-1:0]    stab;
  logic             qualified;
  logic             commit;

  assign qualified = (s2 == cand) && (stab == STAB_MAX);
  assign commit    = (state == SETTLE) && qualified && (cand != count);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= ripple_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand     <= '0;
      stab     <= '0;
      count    <= '0;
      update   <= 1'b0;
      settling <= 1'b0;
      state    <= TRACK;
    end else begin
      update <= 1'b0;

      if (s2 != cand) begin
        cand <= s2;
        stab <= '0;
      end else if (stab < STAB_MAX) begin
        stab <= stab + 1'b1;
      end

      // cand always equals count while in TRACK, so any s2 difference starts qualification
      case (state)
        TRACK: begin
          if (s2 != count) begin
            state    <= SETTLE;
            settling <= 1'b1;
          end
        end
        SETTLE: begin
          if (s2 != cand) begin
            if (s2 == count) begin
              state    <= TRACK;
              settling <= 1'b0;
            end
          end else if (commit) begin
            count    <= cand;
            update   <= 1'b1;
            state    <= TRACK;
            settling <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef RIPPLE_SAMPLER_SEQ_CHECK_EN
  logic [WIDTH-1:0] next_exp;
  logic             mismatch;

  assign next_exp = count + 1'b1;
  assign mismatch = commit && (cand != next_exp);

  // an error on the same cycle as clear_err leaves a fresh count of one
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_err   <= 1'b0;
      err_count <= 8'd0;
    end else if (mismatch) begin
      seq_err   <= 1'b1;
      if (clear_err) begin
        err_count <= 8'd1;
      end else if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end else if (clear_err) begin
      seq_err   <= 1'b0;
      err_count <= 8'd0;
    end
  end
`else
  logic unused_clear_err;
  assign unused_clear_err = clear_err;
`endif

endmodule

// File: doc/ripple_sampler.md
# ripple_sampler

Synchronous capture stage that sits directly downstream of the 8-tap ripple clock divider. It brings the divider's tap vector (the slow blink clock plus its /2 to /128 taps) into the main `clk` domain through a two-flop synchronizer. Because the taps of a ripple counter do not all switch on the same edge, it rejects transient values with a stability filter and publishes a clean settled count with a one-cycle update strobe. It also checks that each settled value is the previous one plus one and reports violations, so downstream logic (LED/USB reporting) can treat the count as a trusted binary value.

## Interface
- `WIDTH`, 8: width of the tap vector and of `count`.
- `STABLE_CYCLES`, 4: consecutive `clk` cycles the synchronized vector must hold before it is accepted. Must be ≥1.

- `clk` in 1: system clock, single clock domain for all logic.
- `rst` in 1: synchronous, active-high reset, taken from the reset conditioner output.
- `ripple_in` in WIDTH: raw divider taps, asynchronous to `clk`. Bit 0 is the slow blink clock and bit k is the /2^k tap.
- `clear_err` in 1: synchronous clear of the error flag and error counter.
- `count` out WIDTH: last accepted settled value.
- `update` out 1: single-cycle pulse, high in the same cycle `count` takes a new value.
- `settling` out 1: high while a candidate value differing from `count` is being qualified.
- `seq_err` out 1: sticky sequence-error flag. Present only with `RIPPLE_SAMPLER_SEQ_CHECK_EN`.
- `err_count` out 8: saturating count of sequence errors. Present only with `RIPPLE_SAMPLER_SEQ_CHECK_EN`.

## Operation
- Synchronizer: `s1 <= ripple_in`, `s2 <= s1`. No logic between the two stages.
- Internal state: `cand` (WIDTH bits) and `stab`, which is wide enough to hold STABLE_CYCLES-1.
- Each cycle the block first compares `s2` with `cand`:
  - If `s2 != cand`: `cand <= s2`, `stab <= 0`.
  - Else if `stab < STABLE_CYCLES-1`: `stab <= stab+1`.
  - Else, when `stab == STABLE_CYCLES-1`, the candidate is qualified.
- FSM, two states:
  - TRACK: `cand == count`. Goes to SETTLE when `s2` differs from `count`.
  - SETTLE: qualifying `cand`.
    - If the qualify condition is met with `cand != count`, the block commits: `count <= cand`, `update <= 1`, and returns to TRACK.
    - If `cand` returns to `count` before it qualifies, the block goes back to TRACK with no update.
    - A new differing value restarts qualification (`stab <= 0`) and stays in SETTLE.
- `settling` is high exactly in SETTLE.
- Glitches shorter than STABLE_CYCLES cycles never reach `count`.
- Sequence check (macro enabled), evaluated on the commit cycle:
  - Expected value is `(count + 1) mod 2^WIDTH`. Wrap from 2^WIDTH-1 to 0 is legal.
  - On mismatch: `seq_err <= 1`, and `err_count` increments, saturating at 255.
  - The first commit after reset is checked against an expected value of 1.
- `clear_err` zeroes `seq_err` and `err_count`. If it coincides with a mismatching commit, the error wins: `seq_err` = 1, `err_count` = 1.
- Reset mid-operation:
  - All registers return to reset values on the next edge.
  - An in-progress qualification is discarded and no `update` is issued.

## Timing
- Reset values: `s1`, `s2`, `cand`, `count`, `stab` = 0; `update`, `settling`, `seq_err` = 0; `err_count` = 0; FSM = TRACK.
- Latency: a `ripple_in` change first sampled at edge N reaches `s2` at N+1, loads `cand` at N+2, and commits at edge N+2+STABLE_CYCLES.
  - With defaults, `count`/`update` are valid after edge N+6.
- `update` lasts exactly one cycle. Back-to-back commits are spaced by at least STABLE_CYCLES+1 cycles.
- `seq_err` and `err_count` change on the same edge as the offending commit.
- `count` holds its value between commits. There is no handshake and no back-pressure; consumers sample on `update`.

## Configuration
- `RIPPLE_SAMPLER_SEQ_CHECK_EN` defined:
  - Sequence checker, `seq_err`, and `err_count` are built as specified.
  - `clear_err` is functional.
- `RIPPLE_SAMPLER_SEQ_CHECK_EN` undefined:
  - Checker logic is absent, and the `seq_err` and `err_count` ports are removed.
  - `clear_err` remains as a port and is ignored.
  - Capture and filtering behaviour is unchanged.

## Test plan
- Reset, then hold `ripple_in`=0 for 20 cycles -> `count`=0, `update` never high, `settling`=0.
- Step `ripple_in` 0→1 and hold (defaults) -> `settling` rises, then `update` pulses once 6 cycles after the first sampling edge, with `count`=1 and `seq_err`=0.
- Apply glitch 1→3 for 2 cycles, then back to 1 -> no `update`, `count` stays 1, `settling` returns to 0.
- Step 1→5 and hold (macro on) -> `count`=5, `seq_err`=1, `err_count`=1. Pulse `clear_err` -> both return to 0.
- Sweep `count` 0xFE→0xFF→0x00 -> two updates, no error on the wrap. Force 300 mismatched commits -> `err_count` saturates at 255.
- Assert `rst` during SETTLE with `ripple_in`=7 -> no `update`, all outputs 0 on the next edge. After release, `count` becomes 7 once qualification completes.
